// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 8-bit DDS samples into 16-bit SPI frames for a DAC.
// Each frame is {CTRL, sample, 4'b0000}, sent MSB first with chip select
// framing, a fixed setup, hold and gap, and SCLK at sys_clk / (2*CLK_DIV).
// Samples offered while a frame is in flight are dropped and counted.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic [3:0]  CTRL    = 4'b0000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       frame_done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Every phase and every SCLK half-period lasts CLK_DIV cycles, so the
    // divider counts CLK_DIV-1 down to 0 and expires on the last cycle.
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t      state_r, state_nx_s;
    logic [7:0]  div_r, div_nx_s;
    logic [4:0]  half_r, half_nx_s;
    logic [15:0] shreg_r, shreg_nx_s;
    logic        sclk_r, sclk_nx_s;
    logic        cs_n_r, cs_n_nx_s;
    logic        din_r, din_nx_s;
    logic        frame_done_r, frame_done_nx_s;
    logic [7:0]  drop_r, drop_nx_s;
    logic        expire_s;

    assign expire_s = (div_r == 8'd0);

    // Next-state, divider, shift register and serial output decoding.
    always_comb begin
        state_nx_s = state_r;
        div_nx_s   = expire_s ? 8'd0 : (div_r - 8'd1);
        half_nx_s  = half_r;
        shreg_nx_s = shreg_r;
        sclk_nx_s  = sclk_r;
        cs_n_nx_s  = cs_n_r;
        din_nx_s   = din_r;
        case (state_r)
            IDLE: begin
                if (sample_valid) begin
                    state_nx_s = SETUP;
                    div_nx_s   = DIV_RELOAD;
                    shreg_nx_s = {CTRL, sample_in, 4'b0000};
                    din_nx_s   = CTRL[3];
                    cs_n_nx_s  = 1'b0;
                    sclk_nx_s  = 1'b0;
                end else begin
                    div_nx_s   = div_r;
                end
            end
            SETUP: begin
                if (expire_s) begin
                    // Leaving SETUP is the first rising SCLK edge.
                    state_nx_s = SHIFT;
                    div_nx_s   = DIV_RELOAD;
                    sclk_nx_s  = 1'b1;
                    half_nx_s  = 5'd0;
                end else begin
                    state_nx_s = SETUP;
                end
            end
            SHIFT: begin
                if (expire_s) begin
                    div_nx_s = DIV_RELOAD;
                    if (half_r == 5'd31) begin
                        // 32nd half-period ends with SCLK already low.
                        state_nx_s = HOLD;
                    end else begin
                        half_nx_s = half_r + 5'd1;
                        sclk_nx_s = ~sclk_r;
                        if (sclk_r) begin
                            // Falling edge: present the next lower bit.
                            shreg_nx_s = {shreg_r[14:0], 1'b0};
                            din_nx_s   = shreg_r[14];
                        end else begin
                            din_nx_s   = din_r;
                        end
                    end
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            HOLD: begin
                if (expire_s) begin
                    state_nx_s = GAP;
                    div_nx_s   = DIV_RELOAD;
                    cs_n_nx_s  = 1'b1;
                    din_nx_s   = 1'b0;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            GAP: begin
                if (expire_s) begin
                    state_nx_s = IDLE;
                    div_nx_s   = DIV_RELOAD;
                end else begin
                    state_nx_s = GAP;
                end
            end
            default: begin
                state_nx_s = IDLE;
                div_nx_s   = DIV_RELOAD;
                cs_n_nx_s  = 1'b1;
                sclk_nx_s  = 1'b0;
                din_nx_s   = 1'b0;
            end
        endcase
        // Pulse covers the final GAP cycle, so ready rises right after it.
        frame_done_nx_s = (state_nx_s == GAP) && (div_nx_s == 8'd0);
        if (sample_valid && (state_r != IDLE) && (drop_r != 8'hFF)) begin
            drop_nx_s = drop_r + 8'd1;
        end else begin
            drop_nx_s = drop_r;
        end
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            div_r        <= DIV_RELOAD;
            half_r       <= 5'd0;
            shreg_r      <= 16'd0;
            sclk_r       <= 1'b0;
            cs_n_r       <= 1'b1;
            din_r        <= 1'b0;
            frame_done_r <= 1'b0;
            drop_r       <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            div_r        <= div_nx_s;
            half_r       <= half_nx_s;
            shreg_r      <= shreg_nx_s;
            sclk_r       <= sclk_nx_s;
            cs_n_r       <= cs_n_nx_s;
            din_r        <= din_nx_s;
            frame_done_r <= frame_done_nx_s;
            drop_r       <= drop_nx_s;
        end
    end

    assign ready      = (state_r == IDLE);
    assign dac_cs_n   = cs_n_r;
    assign dac_sclk   = sclk_r;
    assign dac_din    = din_r;
    assign frame_done = frame_done_r;
    assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: one instance at CLK_DIV=2/CTRL=0 and one at
// CLK_DIV=1/CTRL=4'b1001, observed through a shared select.
module tb_dac_spi_tx;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       valid;
    logic       sel;
    logic       valid_a, valid_b;

    logic       ready_a, cs_n_a, sclk_a, din_a, fd_a;
    logic [7:0] drop_a;
    logic       ready_b, cs_n_b, sclk_b, din_b, fd_b;
    logic [7:0] drop_b;

    logic       obs_ready, obs_cs_n, obs_sclk, obs_din, obs_fd;
    logic [7:0] obs_drop;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    assign valid_a   = valid & ~sel;
    assign valid_b   = valid & sel;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_cs_n  = sel ? cs_n_b  : cs_n_a;
    assign obs_sclk  = sel ? sclk_b  : sclk_a;
    assign obs_din   = sel ? din_b   : din_a;
    assign obs_fd    = sel ? fd_b    : fd_a;
    assign obs_drop  = sel ? drop_b  : drop_a;

    dac_spi_tx #(.CLK_DIV(2), .CTRL(4'b0000)) dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .sample_in(sample_in),
        .sample_valid(valid_a), .ready(ready_a), .dac_cs_n(cs_n_a),
        .dac_sclk(sclk_a), .dac_din(din_a), .frame_done(fd_a),
        .drop_cnt(drop_a)
    );

    dac_spi_tx #(.CLK_DIV(1), .CTRL(4'b1001)) dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .sample_in(sample_in),
        .sample_valid(valid_b), .ready(ready_b), .dac_cs_n(cs_n_b),
        .dac_sclk(sclk_b), .dac_din(din_b), .frame_done(fd_b),
        .drop_cnt(drop_b)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one sample, then watches the frame until ready returns
    // (bounded). Indices k count cycles after the accept cycle T.
    task automatic run_frame(input logic [7:0] s, input bit hold,
                             output logic [15:0] bits, output int rises,
                             output int first_low, output int last_low,
                             output int fd_at, output int fd_n,
                             output int ready_at, output int glitch);
        logic prev_sclk;
        bits = 16'd0; rises = 0; first_low = -1; last_low = -1;
        fd_at = -1; fd_n = 0; ready_at = -1; glitch = 0;
        sample_in = s;
        valid     = 1'b1;
        check("ready_at_accept", {31'd0, obs_ready}, 32'd1);
        prev_sclk = obs_sclk;
        tick();
        sample_in = ~s;
        if (!hold) valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (obs_sclk && !prev_sclk) begin
                rises++;
                bits = {bits[14:0], obs_din};
            end
            if (obs_sclk && obs_cs_n) glitch++;
            if (!obs_cs_n) begin
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (obs_fd) begin
                fd_at = k;
                fd_n++;
            end
            if (obs_ready) begin
                ready_at = k;
                break;
            end
            prev_sclk = obs_sclk;
            tick();
        end
    endtask

    logic [15:0] bits;
    int rises, first_low, last_low, fd_at, fd_n, ready_at, glitch;
    int wraps, cnt;
    logic [7:0] last_drop;
    logic prev;

    initial begin
        rst_n = 1'b0; valid = 1'b0; sel = 1'b0; sample_in = 8'h00;
        #12;
        check("rst_ready",   {31'd0, ready_a}, 32'd1);
        check("rst_cs_n",    {31'd0, cs_n_a},  32'd1);
        check("rst_sclk",    {31'd0, sclk_a},  32'd0);
        check("rst_din",     {31'd0, din_a},   32'd0);
        check("rst_fd",      {31'd0, fd_a},    32'd0);
        check("rst_drop",    {24'd0, drop_a},  32'd0);
        check("rst_b_cs_n",  {31'd0, cs_n_b},  32'd1);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;

        // Single frame 8'hA5, accepted on the first edge after release.
        run_frame(8'hA5, 1'b0, bits, rises, first_low, last_low, fd_at, fd_n, ready_at, glitch);
        check("a5_bits",      {16'd0, bits}, 32'h0A50);
        check("a5_rises",     rises, 32'd16);
        check("a5_cs_first",  first_low, 32'd1);
        check("a5_cs_last",   last_low, 32'd68);
        check("a5_fd_at",     fd_at, 32'd70);
        check("a5_fd_n",      fd_n, 32'd1);
        check("a5_ready_at",  ready_at, 32'd71);
        check("a5_glitch",    glitch, 32'd0);
        check("a5_din_end",   {31'd0, obs_din}, 32'd0);
        check("a5_drop",      {24'd0, obs_drop}, 32'd0);

        // Back-to-back with valid held high: 8'h00 then 8'hFF.
        run_frame(8'h00, 1'b1, bits, rises, first_low, last_low, fd_at, fd_n, ready_at, glitch);
        check("b2b0_bits",    {16'd0, bits}, 32'h0000);
        check("b2b0_ready",   ready_at, 32'd71);
        check("b2b0_drop",    {24'd0, obs_drop}, 32'd70);
        run_frame(8'hFF, 1'b1, bits, rises, first_low, last_low, fd_at, fd_n, ready_at, glitch);
        check("b2b1_cs_first", first_low, 32'd1);
        check("b2b1_bits",    {16'd0, bits}, 32'h0FF0);
        check("b2b1_rises",   rises, 32'd16);
        check("b2b1_ready",   ready_at, 32'd71);
        check("b2b1_drop",    {24'd0, obs_drop}, 32'd140);

        // Saturation: keep valid asserted for 300 more cycles.
        wraps = 0;
        last_drop = obs_drop;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (obs_drop < last_drop) wraps++;
            last_drop = obs_drop;
        end
        valid = 1'b0;
        check("sat_drop",  {24'd0, obs_drop}, 32'd255);
        check("sat_wraps", wraps, 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (obs_ready) break;
            tick();
        end
        check("sat_idle", {31'd0, obs_ready}, 32'd1);

        // Reset in the middle of a frame, after the 5th SCLK rise.
        sample_in = 8'h5A; valid = 1'b1;
        tick();
        valid = 1'b0;
        prev = 1'b0; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (obs_sclk && !prev) cnt++;
            if (cnt == 5) break;
            prev = obs_sclk;
            tick();
        end
        check("mid_rises", cnt, 32'd5);
        check("mid_cs_low", {31'd0, obs_cs_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n",  {31'd0, obs_cs_n},  32'd1);
        check("mid_rst_sclk",  {31'd0, obs_sclk},  32'd0);
        check("mid_rst_ready", {31'd0, obs_ready}, 32'd1);
        check("mid_rst_drop",  {24'd0, obs_drop},  32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_cs_n", {31'd0, obs_cs_n}, 32'd1);
        run_frame(8'h3C, 1'b0, bits, rises, first_low, last_low, fd_at, fd_n, ready_at, glitch);
        check("post_bits",    {16'd0, bits}, 32'h03C0);
        check("post_rises",   rises, 32'd16);
        check("post_ready",   ready_at, 32'd71);

        // CLK_DIV=1, CTRL=4'b1001, sample 8'h3C.
        sel = 1'b1;
        run_frame(8'h3C, 1'b0, bits, rises, first_low, last_low, fd_at, fd_n, ready_at, glitch);
        check("d1_bits",      {16'd0, bits}, 32'h93C0);
        check("d1_rises",     rises, 32'd16);
        check("d1_cs_last",   last_low, 32'd34);
        check("d1_fd_at",     fd_at, 32'd35);
        check("d1_ready_at",  ready_at, 32'd36);
        check("d1_glitch",    glitch, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
